// File: rtl/vs_ring_buffer_pkg.sv
// Shared command words, register selects and bus FSM encoding for the
// value-storage ring buffer.
package vs_ring_pkg;
    localparam logic [15:0] VS_CMD_FREEZE = 16'h0000;
    localparam logic [15:0] VS_CMD_RUN    = 16'hffff;
    localparam logic [15:0] VS_EMPTY_WORD = 16'h8000;

    localparam logic VS_REG_DATA   = 1'b0;
    localparam logic VS_REG_STATUS = 1'b1;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_RD   = 2'd1,
        BUS_ACK  = 2'd2
    } bus_state_e;
endpackage

// File: rtl/vs_ring_buffer_if.sv
// Wishbone slave signal bundle for the value-storage ring buffer.
interface vs_ring_buffer_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic        wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/vs_ring_ram.sv
// Simple dual-port sample RAM: one write port, one synchronous read port.
module vs_ring_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [14:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [14:0]       rdata
);
    logic [14:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/vs_ring_buffer.sv
// Circular sample history behind a Wishbone register pair; the bus side can
// freeze capture, drain oldest-first, and resume with an empty history.
module vs_ring_buffer
    import vs_ring_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    vs_ring_buffer_if.slave  bus,
    input  logic             value_valid_i,
    input  logic [14:0]      value_i
);
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    bus_state_e        state, state_nxt;
    logic              req_we;
    logic              req_adr;
    logic [15:0]       req_dat;

    logic              frozen;
    logic [ADDR_W:0]   count, count_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [14:0]       ram_q;

    logic              do_pop, do_freeze, do_resume, sample_take;
    logic [15:0]       dat_mux, status_word;

    vs_ring_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (wb_clk_i),
        .we    (sample_take),
        .waddr (wr_ptr),
        .wdata (value_i),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= BUS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = BUS_IDLE;
        case (state)
            BUS_IDLE: state_nxt = (bus.wb_cyc_i && bus.wb_stb_i) ? BUS_RD : BUS_IDLE;
            BUS_RD:   state_nxt = BUS_ACK;
            default:  state_nxt = BUS_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            req_we  <= 1'b0;
            req_adr <= VS_REG_DATA;
            req_dat <= '0;
        end else if (state == BUS_IDLE && bus.wb_cyc_i && bus.wb_stb_i) begin
            req_we  <= bus.wb_we_i;
            req_adr <= bus.wb_adr_i;
            req_dat <= bus.wb_dat_i;
        end
    end

    // All bus side effects happen in the single ACK cycle, alongside the data.
    always_comb begin
        dat_mux     = '0;
        do_pop      = 1'b0;
        do_freeze   = 1'b0;
        do_resume   = 1'b0;
        status_word = '0;
        status_word[ADDR_W:0] = count;
        status_word[15]       = frozen;
        if (state == BUS_ACK) begin
            if (req_we) begin
                if (req_adr == VS_REG_DATA) begin
                    if (req_dat == VS_CMD_FREEZE && !frozen) begin
                        do_freeze = 1'b1;
                    end else if (req_dat == VS_CMD_RUN) begin
                        do_resume = 1'b1;
                    end
                end
            end else if (req_adr == VS_REG_STATUS) begin
                dat_mux = status_word;
            end else if (frozen && count != '0) begin
                dat_mux = {(count == CNT_ONE), ram_q};
                do_pop  = 1'b1;
            end else begin
                dat_mux = VS_EMPTY_WORD;
            end
        end
    end

    assign sample_take = value_valid_i && !frozen && !do_resume;
    assign wr_ptr_nxt  = sample_take ? wr_ptr + PTR_ONE : wr_ptr;
    assign count_nxt   = (sample_take && count != CNT_FULL) ? count + CNT_ONE : count;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || do_resume) begin
            frozen <= 1'b0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            count  <= count_nxt;
            if (do_freeze) begin
                // A sample landing in the freeze cycle is part of the dump.
                frozen <= 1'b1;
                rd_ptr <= wr_ptr_nxt - count_nxt[ADDR_W-1:0];
            end else if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count - CNT_ONE;
            end
        end
    end

    assign bus.wb_dat_o = dat_mux;
    assign bus.wb_ack_o = (state == BUS_ACK);
    assign bus.wb_err_o = 1'b0;
endmodule

// File: tb/tb_vs_ring_buffer.sv
// Directed bench for vs_ring_buffer (depth 8) with hand-computed expectations.
module tb_vs_ring_buffer;
    logic        clk;
    logic        rst;
    logic        vv;
    logic [14:0] vval;
    int          n_checks;
    int          n_pass;

    vs_ring_buffer_if bus ();

    vs_ring_buffer #(.ADDR_W(3)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .bus           (bus),
        .value_valid_i (vv),
        .value_i       (vval)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic adr, input logic [15:0] dat,
                        input bit inj, input logic [14:0] sv,
                        output logic [15:0] rdata, output logic [15:0] lat);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        rdata = '0;
        lat   = '0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.wb_cyc_i = 1'b0;
                bus.wb_stb_i = 1'b0;
                bus.wb_we_i  = 1'b0;
            end
            if (bus.wb_ack_o) begin
                lat   = 16'(i);
                rdata = bus.wb_dat_o;
                if (inj) begin
                    vv   = 1'b1;
                    vval = sv;
                end
                break;
            end
        end
        @(negedge clk);
        vv = 1'b0;
    endtask

    task automatic rd(input logic adr, input logic [15:0] exp, input string tag);
        logic [15:0] d, l;
        xfer(1'b0, adr, 16'h0, 1'b0, 15'h0, d, l);
        chk(tag, d, exp);
        chk({tag, "_lat"}, l, 16'd2);
    endtask

    task automatic wr(input logic adr, input logic [15:0] dat, input bit inj,
                      input logic [14:0] sv, input string tag);
        logic [15:0] d, l;
        xfer(1'b1, adr, dat, inj, sv, d, l);
        chk({tag, "_lat"}, l, 16'd2);
    endtask

    task automatic inject(input logic [14:0] v);
        vv   = 1'b1;
        vval = v;
        @(negedge clk);
        vv   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        vv = 1'b0;
        vval = '0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 1'b0;
        bus.wb_dat_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", {15'h0, bus.wb_ack_o}, 16'h0);
        chk("rst_dat", bus.wb_dat_o, 16'h0);
        chk("rst_err", {15'h0, bus.wb_err_o}, 16'h0);
        rst = 1'b0;
        @(negedge clk);
        rd(1'b1, 16'h0000, "rst_status");

        // basic fill and drain
        for (int i = 1; i <= 5; i++) inject(15'(i));
        wr(1'b0, 16'h0000, 1'b0, 15'h0, "freeze1");
        rd(1'b0, 16'h0001, "basic_r1");
        rd(1'b0, 16'h0002, "basic_r2");
        rd(1'b0, 16'h0003, "basic_r3");
        rd(1'b0, 16'h0004, "basic_r4");
        rd(1'b0, 16'h8005, "basic_r5");
        rd(1'b0, 16'h8000, "basic_r6");
        rd(1'b1, 16'h8000, "basic_status");

        // wrap-around with saturation
        wr(1'b0, 16'hffff, 1'b0, 15'h0, "resume1");
        for (int i = 1; i <= 11; i++) inject(15'(i));
        wr(1'b0, 16'h0000, 1'b0, 15'h0, "freeze2");
        rd(1'b1, 16'h8008, "wrap_status");
        for (int i = 4; i <= 10; i++) rd(1'b0, 16'(i), "wrap_rd");
        rd(1'b0, 16'h800b, "wrap_last");
        rd(1'b0, 16'h8000, "wrap_empty");

        // sample in the freeze commit cycle is kept
        wr(1'b0, 16'hffff, 1'b0, 15'h0, "resume2");
        inject(15'h0011);
        inject(15'h0022);
        wr(1'b0, 16'h0000, 1'b1, 15'h0abc, "freeze3");
        rd(1'b1, 16'h8003, "fb_status");
        rd(1'b0, 16'h0011, "fb_r1");
        rd(1'b0, 16'h0022, "fb_r2");
        rd(1'b0, 16'h8abc, "fb_last");

        // frozen drops, repeated freeze, resume drops commit-cycle sample
        wr(1'b0, 16'hffff, 1'b0, 15'h0, "resume3");
        inject(15'h0055);
        wr(1'b0, 16'h0000, 1'b0, 15'h0, "freeze4");
        rd(1'b1, 16'h8001, "drop_status0");
        for (int i = 0; i < 3; i++) inject(15'h0066);
        rd(1'b1, 16'h8001, "drop_status1");
        wr(1'b0, 16'h0000, 1'b0, 15'h0, "refreeze");
        rd(1'b1, 16'h8001, "refreeze_status");
        wr(1'b0, 16'hffff, 1'b1, 15'h7777, "resume4");
        inject(15'h0002);
        inject(15'h0003);
        wr(1'b0, 16'h0000, 1'b0, 15'h0, "freeze5");
        rd(1'b1, 16'h8002, "resume_status");
        rd(1'b0, 16'h0002, "resume_r1");
        rd(1'b0, 16'h8003, "resume_r2");

        // read and ignored writes while running
        wr(1'b0, 16'hffff, 1'b0, 15'h0, "resume5");
        rd(1'b0, 16'h8000, "run_read");
        wr(1'b0, 16'h1234, 1'b0, 15'h0, "other_wr");
        rd(1'b1, 16'h0000, "run_status0");
        inject(15'h0044);
        rd(1'b1, 16'h0001, "run_status1");
        wr(1'b1, 16'h0000, 1'b0, 15'h0, "status_wr");
        rd(1'b1, 16'h0001, "run_status2");

        // reset mid-transaction
        wr(1'b0, 16'h0000, 1'b0, 15'h0, "freeze6");
        rd(1'b1, 16'h8001, "pre_rst_status");
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 1'b0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack", {15'h0, bus.wb_ack_o}, 16'h0);
        chk("mid_rst_dat", bus.wb_dat_o, 16'h0);
        chk("mid_rst_err", {15'h0, bus.wb_err_o}, 16'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ack", {15'h0, bus.wb_ack_o}, 16'h0);
        @(negedge clk);
        chk("post_rst_ack2", {15'h0, bus.wb_ack_o}, 16'h0);
        rd(1'b1, 16'h0000, "post_rst_status");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
